mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, memory data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, maximum consecutive data grants while fetch pending.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum BUSY cycles without m_ack.
REQ-005 SHALL have ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request, level, held until f_ack.
- f_addr  in  ADDR_WIDTH  fetch address, stable while f_req.
- f_ack  out  1  one-cycle fetch completion pulse.
- f_rdata  out  DATA_WIDTH  fetch read data, valid with f_ack.
- d_req  in  1  data request, level, held until d_ack.
- d_we  in  1  data write enable.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  write data.
- d_be  in  DATA_WIDTH/8  byte enables.
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  DATA_WIDTH  data read data, valid with d_ack.
- m_req, m_we, m_addr, m_wdata, m_be  out  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  registered memory request.
- m_ack  in  1  memory completion.
- m_rdata  in  DATA_WIDTH  memory read data, valid with m_ack.
- trap  out  4  trap code, 0 = none.

Function
REQ-006 SHALL implement states IDLE, BUSY_F, BUSY_D, RESP, HALT.
REQ-007 In IDLE with any request, SHALL register the granted port's request onto m_* and go to the matching BUSY state next edge; m_req=1 throughout BUSY.
REQ-008 SHALL grant d_req over f_req unless the starve counter equals STARVE_LIMIT, in which case f_req wins.
REQ-009 Starve counter: +1 on each data grant with f_req=1; cleared on fetch grant or when f_req=0 in IDLE; saturates at STARVE_LIMIT.
REQ-010 In BUSY with m_ack=1, SHALL capture m_rdata, deassert m_req next edge, and go to RESP.
REQ-011 In RESP, SHALL drive exactly one of f_ack/d_ack (matching the BUSY state) for one cycle with rdata; next state IDLE.
REQ-012 Minimum latency: request sampled in IDLE at edge N, m_ack in first BUSY cycle -> ack high in cycle N+2.
REQ-013 m_ack outside BUSY SHALL be ignored.
REQ-014 f_rdata/d_rdata SHALL hold their last value between acks.
REQ-015 Requests arriving during BUSY/RESP SHALL wait; none dropped.

Reset
REQ-016 reset=0 SHALL asynchronously force IDLE, counters 0, all outputs 0 including m_req, acks, rdata, trap, regardless of in-flight transaction.
REQ-017 After reset release, first grant SHALL occur on the first clk edge with a request.

Configuration
REQ-018 With MEM_ARBITER_TIMEOUT_EN defined: BUSY cycle counter; reaching TIMEOUT without m_ack SHALL drop m_req, set trap=TRAP_MEM_TIMEOUT (sticky until reset), enter HALT; HALT grants nothing.
REQ-019 Without MEM_ARBITER_TIMEOUT_EN: BUSY waits indefinitely, HALT unreachable, trap constant 0.

Structure
REQ-020 Package wasm_mem_pkg SHALL hold state encoding and TRAP_MEM_TIMEOUT (4'h4).
REQ-021 Timeout counter SHALL be sub-module mem_arbiter_timer, instantiated only under MEM_ARBITER_TIMEOUT_EN.

Verification
REQ-022 Single fetch f_addr=0x10, m_ack first BUSY cycle, m_rdata=0xDEAD -> f_ack in cycle N+2, f_rdata=0xDEAD, d_ack=0.
REQ-023 f_req and d_req both held, STARVE_LIMIT=4, m_ack immediate -> grants D,D,D,D,F,D...
REQ-024 Data write d_we=1, d_be=0xFF, d_wdata=0x1234 -> m_we=1, m_wdata=0x1234, m_be=0xFF until m_ack; d_ack one cycle.
REQ-025 reset low during BUSY_D -> m_req=0, d_ack=0, trap=0 immediately; next request granted normally.
REQ-026 With MEM_ARBITER_TIMEOUT_EN, TIMEOUT=8, m_ack never -> after 8 BUSY cycles m_req=0, trap=4'h4 held; later f_req not granted until reset.

Source files
------------

// File: rtl/wasm_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : wasm_mem_pkg                                               |
// | Brief   : Arbiter FSM state encoding and trap codes shared by the    |
// |           memory arbiter and its helpers.                            |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package wasm_mem_pkg;

  // Arbiter states; HALT is only reachable when the timeout watchdog is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_F = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_RESP   = 3'd3,
    ST_HALT   = 3'd4
  } arb_state_t;

  localparam logic [3:0] TRAP_NONE        = 4'h0;
  localparam logic [3:0] TRAP_MEM_TIMEOUT = 4'h4;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mem_arbiter_timer                                          |
// | Brief   : Counts consecutive BUSY cycles without a memory ack and    |
// |           flags the cycle in which the TIMEOUT-th one ends.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mem_arbiter_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_expired
);

  localparam int              c_CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);

  logic [c_CW-1:0] r_cnt;

  // Count BUSY cycles; any ack or leaving BUSY restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_busy || i_ack) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CW'(1);
    end
  end

  // Fires during the last permitted BUSY cycle so the FSM leaves BUSY on its closing edge.
  assign o_expired = i_busy && !i_ack && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mem_arbiter                                                |
// | Brief   : Two-port (fetch/data) arbiter onto a single registered     |
// |           memory request channel, with fetch starvation guard.      |
// |           Define MEM_ARBITER_TIMEOUT_EN to build in the BUSY         |
// |           watchdog that traps and halts on a missing memory ack.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mem_arbiter
  import wasm_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    f_req,
  input  logic [ADDR_WIDTH-1:0]   f_addr,
  output logic                    f_ack,
  output logic [DATA_WIDTH-1:0]   f_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_ack,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    m_req,
  output logic                    m_we,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_be,
  input  logic                    m_ack,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  output logic [3:0]              trap
);

  localparam int              c_SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);

  arb_state_t              r_state;
  logic [c_SW-1:0]         r_starve;
  logic                    r_f_ack;
  logic                    r_d_ack;
  logic [DATA_WIDTH-1:0]   r_f_rdata;
  logic [DATA_WIDTH-1:0]   r_d_rdata;
  logic                    r_m_req;
  logic                    r_m_we;
  logic [ADDR_WIDTH-1:0]   r_m_addr;
  logic [DATA_WIDTH-1:0]   r_m_wdata;
  logic [DATA_WIDTH/8-1:0] r_m_be;
  logic [3:0]              r_trap;

  logic w_grant_d;
  logic w_grant_f;
  logic w_timeout;

  // Data normally wins; once fetch has lost STARVE_LIMIT times in a row it gets the slot.
  assign w_grant_d = d_req && !(f_req && (r_starve == c_STARVE_MAX));
  assign w_grant_f = f_req && !w_grant_d;

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic w_busy;
  assign w_busy = (r_state == ST_BUSY_F) || (r_state == ST_BUSY_D);

  mem_arbiter_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (reset),
    .i_busy    (w_busy),
    .i_ack     (m_ack),
    .o_expired (w_timeout)
  );
`else
  // Without the watchdog a BUSY state waits for m_ack forever.
  localparam int c_unused_timeout = TIMEOUT;
  assign w_timeout = 1'b0;
`endif

  // Arbiter FSM: grant, memory handshake, response pulse, and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_starve  <= '0;
      r_f_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_f_rdata <= '0;
      r_d_rdata <= '0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_m_be    <= '0;
      r_trap    <= TRAP_NONE;
    end else begin
      r_f_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_m_req   <= 1'b1;
            r_m_we    <= d_we;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wdata;
            r_m_be    <= d_be;
            r_state   <= ST_BUSY_D;
          end else if (w_grant_f) begin
            // Fetches are full-word reads.
            r_m_req   <= 1'b1;
            r_m_we    <= 1'b0;
            r_m_addr  <= f_addr;
            r_m_wdata <= '0;
            r_m_be    <= '1;
            r_state   <= ST_BUSY_F;
          end
          if (!f_req || w_grant_f) begin
            r_starve <= '0;
          end else if (w_grant_d) begin
            r_starve <= r_starve + c_SW'(1);
          end
        end
        ST_BUSY_F, ST_BUSY_D: begin
          if (m_ack) begin
            r_m_req <= 1'b0;
            if (r_state == ST_BUSY_F) begin
              r_f_rdata <= m_rdata;
              r_f_ack   <= 1'b1;
            end else begin
              r_d_rdata <= m_rdata;
              r_d_ack   <= 1'b1;
            end
            r_state <= ST_RESP;
          end else if (w_timeout) begin
            r_m_req <= 1'b0;
            r_trap  <= TRAP_MEM_TIMEOUT;
            r_state <= ST_HALT;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign f_ack   = r_f_ack;
  assign d_ack   = r_d_ack;
  assign f_rdata = r_f_rdata;
  assign d_rdata = r_d_rdata;
  assign m_req   = r_m_req;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_be    = r_m_be;
  assign trap    = r_trap;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_mem_arbiter                                             |
// | Brief   : Self-checking bench for mem_arbiter: vector table for      |
// |           single transactions, ack scoreboard, hand sequences for    |
// |           starvation, reset abort and (MEM_ARBITER_TIMEOUT_EN)       |
// |           watchdog behaviour.                                        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_ack;
  logic [DW-1:0] f_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [7:0]    d_be;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [7:0]    m_be;
  logic          m_ack;
  logic [DW-1:0] m_rdata;
  logic [3:0]    trap;

  mem_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (4),
    .TIMEOUT      (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_ack   (f_ack),
    .f_rdata (f_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_be    (d_be),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_be    (m_be),
    .m_ack   (m_ack),
    .m_rdata (m_rdata),
    .trap    (trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    int          delay;
    logic [63:0] rdata;
  } vec_t;

  typedef struct {
    bit          is_d;
    logic [63:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] last_f = '0;
  logic [63:0] last_d = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every ack pulse must match the oldest outstanding grant.
  always @(negedge clk) begin
    if (reset && (f_ack || d_ack)) begin
      chk("ack_onehot", {63'd0, f_ack & d_ack}, 64'd0);
      chk("ack_expected", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_port", {63'd0, d_ack}, {63'd0, e.is_d});
        chk("ack_rdata", d_ack ? d_rdata : f_rdata, e.rdata);
      end
    end
  end

  // One complete transaction on an idle arbiter, minimum latency when delay is 0.
  task automatic run_vec(input vec_t v);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      f_req = 1'b1; f_addr = v.addr;
    end
    cyc();
    chk("grant_m_req", {63'd0, m_req}, 64'd1);
    chk("grant_m_addr", {32'd0, m_addr}, {32'd0, v.addr});
    chk("grant_m_we", {63'd0, m_we}, {63'd0, v.is_d & v.we});
    if (v.is_d) begin
      chk("grant_m_wdata", m_wdata, v.wdata);
      chk("grant_m_be", {56'd0, m_be}, {56'd0, v.be});
    end
    sb.push_back('{v.is_d, v.rdata});
    for (int k = 0; k < v.delay; k++) begin
      cyc();
      chk("wait_m_req", {63'd0, m_req}, 64'd1);
      chk("wait_m_addr", {32'd0, m_addr}, {32'd0, v.addr});
      chk("wait_no_ack", {63'd0, f_ack | d_ack}, 64'd0);
      if (v.is_d) chk("wait_m_wdata", m_wdata, v.wdata);
    end
    m_ack = 1'b1; m_rdata = v.rdata;
    cyc();
    m_ack = 1'b0; m_rdata = ~v.rdata;
    chk("resp_ack", {63'd0, v.is_d ? d_ack : f_ack}, 64'd1);
    chk("resp_other_ack", {63'd0, v.is_d ? f_ack : d_ack}, 64'd0);
    chk("resp_m_req", {63'd0, m_req}, 64'd0);
    chk("resp_hold_other", v.is_d ? f_rdata : d_rdata, v.is_d ? last_f : last_d);
    f_req = 1'b0; d_req = 1'b0;
    if (v.is_d) last_d = v.rdata; else last_f = v.rdata;
    cyc();
    chk("ack_pulse_end", {63'd0, f_ack | d_ack}, 64'd0);
    chk("rdata_hold", v.is_d ? d_rdata : f_rdata, v.rdata);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{0, 0, 32'h0000_0010, 64'h0, 8'h00, 0, 64'h0000_0000_0000_DEAD};
    vecs[1] = '{1, 1, 32'h0000_0200, 64'h0000_0000_0000_1234, 8'hFF, 2, 64'h0};
    vecs[2] = '{1, 0, 32'h0000_0300, 64'h0, 8'h0F, 0, 64'hCAFE_BABE_0000_0001};
    vecs[3] = '{0, 0, 32'hFFFF_FFFC, 64'h0, 8'h00, 1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4] = '{1, 1, 32'h0000_0008, 64'hA5A5_5A5A_0F0F_F0F0, 8'h81, 3, 64'h1111_2222_3333_4444};
    vecs[5] = '{0, 0, 32'h0000_0044, 64'h0, 8'h00, 0, 64'h0};

    reset = 1'b0; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; m_ack = 1'b0; m_rdata = '0;
    repeat (2) cyc();
    chk("rst_m_req", {63'd0, m_req}, 64'd0);
    chk("rst_acks", {62'd0, f_ack, d_ack}, 64'd0);
    chk("rst_f_rdata", f_rdata, 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk("rst_trap", {60'd0, trap}, 64'd0);
    reset = 1'b1;

    // Table-driven single transactions; the first is granted on the first edge after release.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Memory ack while idle must not produce a response or change read data.
    m_ack = 1'b1; m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    repeat (2) cyc();
    chk("idle_ack_m_req", {63'd0, m_req}, 64'd0);
    chk("idle_ack_acks", {62'd0, f_ack, d_ack}, 64'd0);
    chk("idle_ack_f_rdata", f_rdata, last_f);
    chk("idle_ack_d_rdata", d_rdata, last_d);
    m_ack = 1'b0;

    // Both ports held: data wins four times, then the starved fetch, then data again.
    f_req = 1'b1; f_addr = 32'h0000_0F00;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0D00; d_be = 8'hFF;
    for (int g = 0; g < 7; g++) begin
      automatic bit exp_d = (g != 4);
      cyc();
      chk("starve_grant_addr", {32'd0, m_addr}, exp_d ? 64'h0D00 : 64'h0F00);
      chk("starve_grant_req", {63'd0, m_req}, 64'd1);
      sb.push_back('{exp_d, 64'(g + 100)});
      m_ack = 1'b1; m_rdata = 64'(g + 100);
      cyc();
      m_ack = 1'b0;
      cyc();
    end
    f_req = 1'b0; d_req = 1'b0;
    cyc();
    last_f = 64'd104; last_d = 64'd106;
    chk("starve_f_rdata", f_rdata, last_f);
    chk("starve_d_rdata", d_rdata, last_d);

    // Reset asserted mid data write clears everything without waiting for an edge.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0400; d_wdata = 64'h55; d_be = 8'h0F;
    cyc();
    chk("abort_busy_m_req", {63'd0, m_req}, 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_m_req", {63'd0, m_req}, 64'd0);
    chk("abort_d_ack", {63'd0, d_ack}, 64'd0);
    chk("abort_trap", {60'd0, trap}, 64'd0);
    chk("abort_d_rdata", d_rdata, 64'd0);
    d_req = 1'b0;
    cyc();
    reset = 1'b1;
    last_f = '0; last_d = '0;
    run_vec('{0, 0, 32'h0000_0500, 64'h0, 8'h00, 0, 64'h0000_0000_BEEF_0001});

`ifdef MEM_ARBITER_TIMEOUT_EN
    // No memory ack: m_req held 8 BUSY cycles, then trap and halt.
    f_req = 1'b1; f_addr = 32'h0000_0600;
    cyc();
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("to_wait_m_req", {63'd0, m_req}, 64'd1);
      chk("to_wait_trap", {60'd0, trap}, 64'd0);
    end
    cyc();
    chk("to_m_req", {63'd0, m_req}, 64'd0);
    chk("to_trap", {60'd0, trap}, 64'h4);
    m_ack = 1'b1;
    repeat (5) cyc();
    m_ack = 1'b0;
    chk("halt_m_req", {63'd0, m_req}, 64'd0);
    chk("halt_acks", {62'd0, f_ack, d_ack}, 64'd0);
    chk("halt_trap", {60'd0, trap}, 64'h4);
    f_req = 1'b0;
    reset = 1'b0;
    cyc();
    chk("halt_reset_trap", {60'd0, trap}, 64'd0);
    reset = 1'b1;
    last_f = '0; last_d = '0;
    run_vec('{0, 0, 32'h0000_0700, 64'h0, 8'h00, 0, 64'h77});
`else
    // Without the watchdog a missing ack just waits, with no trap.
    f_req = 1'b1; f_addr = 32'h0000_0600;
    cyc();
    sb.push_back('{0, 64'h66});
    repeat (20) cyc();
    chk("nto_m_req", {63'd0, m_req}, 64'd1);
    chk("nto_trap", {60'd0, trap}, 64'd0);
    m_ack = 1'b1; m_rdata = 64'h66;
    cyc();
    m_ack = 1'b0;
    chk("nto_f_ack", {63'd0, f_ack}, 64'd1);
    f_req = 1'b0;
    cyc();
`endif

    repeat (2) cyc();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
